demo_frame_sequencer: RTL and testbench

Frame and part sequencer that sits directly upstream of the VGA effect renderer, between the sync timing generator and the pixel effect logic. It turns the raw `vsync` level into a clean single-cycle frame tick in the `clk` domain, so no logic is clocked on `posedge vsync`. From that tick it maintains the frame counter, the current demo part, the frame-within-part position, a beat tick and a fade level. The renderer consumes these values and they stay stable for a whole frame.

---
 rtl/demo_frame_sequencer.sv | 168 ++++++++++++++++
 tb/tb_demo_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// demo_frame_sequencer
//
// Purpose:
//   Frame and part sequencer placed between the sync timing generator and the
//   pixel effect renderer. It converts the raw vsync level into a single-cycle
//   frame tick in the clk domain. From that tick it maintains a free-running
//   frame counter, the current demo part, the position inside the part, a beat
//   tick and a fade level. Every output is registered and changes only at a
//   frame tick, so the renderer sees stable values for a whole frame.
//
// Parameters:
//   PART_FRAMES  frames per part (power of two, >= 32)
//   NUM_PARTS    number of parts (1..8)
//   BEAT_FRAMES  frames per beat (power of two, <= PART_FRAMES)
//
// Ports:
//   clk            pixel clock
//   rst_n          synchronous active-low reset
//   vsync          active-high vertical sync level
//   pause          freezes frame advance while high
//   step           rising edge requests one frame of advance while paused
//   part_sel_en    part override enable
//   part_sel       requested part for the override
//   frame_tick     one-cycle pulse per vsync rising edge
//   frame_counter  free-running 12-bit frame count
//   part           current part, 0..NUM_PARTS-1
//   frame_in_part  position within the current part
//   beat_tick      one-cycle pulse when an advance lands on a beat boundary
//   fade           brightness level, 3 = full, 0 = black
// -----------------------------------------------------------------------------
module demo_frame_sequencer #(
  parameter int PART_FRAMES = 512,
  parameter int NUM_PARTS   = 6,
  parameter int BEAT_FRAMES = 32,
  localparam int FW         = $clog2(PART_FRAMES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          pause,
  input  logic          step,
  input  logic          part_sel_en,
  input  logic [2:0]    part_sel,
  output logic          frame_tick,
  output logic [11:0]   frame_counter,
  output logic [2:0]    part,
  output logic [FW-1:0] frame_in_part,
  output logic          beat_tick,
  output logic [1:0]    fade
);

  localparam logic [FW-1:0] LAST_FIP  = FW'(PART_FRAMES - 1);
  localparam logic [2:0]    LAST_PART = 3'(NUM_PARTS - 1);
  localparam logic [11:0]   BEAT_MASK = 12'(BEAT_FRAMES - 1);

  // Fade ramps up over the first 12 frames of a part and down over the last
  // 12, in blocks of four frames; full brightness in between.
  function automatic logic [1:0] fade_level(input logic [FW-1:0] f);
    logic [1:0] lvl;
    if (f < FW'(4)) begin
      lvl = 2'd0;
    end else if (f < FW'(8)) begin
      lvl = 2'd1;
    end else if (f < FW'(12)) begin
      lvl = 2'd2;
    end else if (f >= FW'(PART_FRAMES - 4)) begin
      lvl = 2'd0;
    end else if (f >= FW'(PART_FRAMES - 8)) begin
      lvl = 2'd1;
    end else if (f >= FW'(PART_FRAMES - 12)) begin
      lvl = 2'd2;
    end else begin
      lvl = 2'd3;
    end
    return lvl;
  endfunction

  logic          r_vsync_q;
  logic          r_step_q;
  logic          r_step_pending;
  logic          r_frame_tick;
  logic          r_beat_tick;
  logic [11:0]   r_frame_counter;
  logic [2:0]    r_part;
  logic [FW-1:0] r_frame_in_part;
  logic [1:0]    r_fade;

  logic          w_rise;
  logic          w_step_edge;
  logic          w_advance;
  logic          w_override;
  logic [11:0]   w_fc_next;
  logic [2:0]    w_part_next;
  logic [FW-1:0] w_fip_next;

  assign w_rise      = vsync & ~r_vsync_q;
  assign w_step_edge = step & ~r_step_q;
  // A paused sequencer only advances when a step is already pending; a step
  // edge arriving on the same edge as the rise is recorded for the next rise.
  assign w_advance   = w_rise & (~pause | r_step_pending);
  assign w_override  = part_sel_en & (part_sel <= LAST_PART) & (part_sel != r_part);
  assign w_fc_next   = r_frame_counter + 12'd1;

  // Next part / position for an advancing frame; override beats natural wrap.
  always_comb begin
    w_part_next = r_part;
    w_fip_next  = r_frame_in_part;
    if (w_override) begin
      w_part_next = part_sel;
      w_fip_next  = '0;
    end else if (r_frame_in_part == LAST_FIP) begin
      w_fip_next = '0;
      if (r_part >= LAST_PART) begin
        w_part_next = 3'd0;
      end else begin
        w_part_next = r_part + 3'd1;
      end
    end else begin
      w_fip_next = r_frame_in_part + FW'(1);
    end
  end

  // Edge detectors, step bookkeeping and all frame state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // vsync_q/step_q reset high so a level already high at release is not an edge.
      r_vsync_q       <= 1'b1;
      r_step_q        <= 1'b1;
      r_step_pending  <= 1'b0;
      r_frame_tick    <= 1'b0;
      r_beat_tick     <= 1'b0;
      r_frame_counter <= 12'd0;
      r_part          <= 3'd0;
      r_frame_in_part <= '0;
      r_fade          <= 2'd0;
    end else begin
      r_vsync_q    <= vsync;
      r_step_q     <= step;
      r_frame_tick <= w_rise;
      r_beat_tick  <= 1'b0;

      if (!pause) begin
        r_step_pending <= 1'b0;
      end else if (w_advance) begin
        r_step_pending <= 1'b0;
      end else if (w_step_edge) begin
        r_step_pending <= 1'b1;
      end

      if (w_advance) begin
        r_frame_counter <= w_fc_next;
        r_part          <= w_part_next;
        r_frame_in_part <= w_fip_next;
        r_fade          <= fade_level(w_fip_next);
        r_beat_tick     <= ((w_fc_next & BEAT_MASK) == 12'd0);
      end
    end
  end

  assign frame_tick    = r_frame_tick;
  assign frame_counter = r_frame_counter;
  assign part          = r_part;
  assign frame_in_part = r_frame_in_part;
  assign beat_tick     = r_beat_tick;
  assign fade          = r_fade;

endmodule

// File: tb/tb_demo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demo_frame_sequencer
//
// Self-checking bench for demo_frame_sequencer built with PART_FRAMES=32,
// NUM_PARTS=3, BEAT_FRAMES=32. A table of per-frame records covers pause,
// step and override behaviour; hand-written sequences cover simultaneous
// events, part wrap with override, mid-run reset and frame counter wrap.
// -----------------------------------------------------------------------------
module tb_demo_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       pause;
  logic       step;
  logic       part_sel_en;
  logic [2:0] part_sel;
  logic       frame_tick;
  logic [11:0] frame_counter;
  logic [2:0] part;
  logic [4:0] frame_in_part;
  logic       beat_tick;
  logic [1:0] fade;

  int n_total = 0;
  int n_bad   = 0;

  int e_fc, e_part, e_fip;
  int prev_part;
  int ticks;

  demo_frame_sequencer #(
    .PART_FRAMES(32),
    .NUM_PARTS  (3),
    .BEAT_FRAMES(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .pause        (pause),
    .step         (step),
    .part_sel_en  (part_sel_en),
    .part_sel     (part_sel),
    .frame_tick   (frame_tick),
    .frame_counter(frame_counter),
    .part         (part),
    .frame_in_part(frame_in_part),
    .beat_tick    (beat_tick),
    .fade         (fade)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pause;
    int         steps;
    logic       sel_en;
    logic [2:0] sel;
    int         fc;
    int         part;
    int         fip;
    int         fade;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Expected fade for a 32-frame part, written as distance from the part edges.
  function automatic int exp_fade(input int f);
    int edge_dist;
    edge_dist = (f < 16) ? f : (31 - f);
    if (edge_dist < 4)       return 0;
    else if (edge_dist < 8)  return 1;
    else if (edge_dist < 12) return 2;
    else                     return 3;
  endfunction

  task automatic check_frame(input string tag, input int fc, input int pt, input int fip,
                             input int fd, input int bt);
    chk({tag, "_tick"},  32'(frame_tick),    32'd1);
    chk({tag, "_fc"},    32'(frame_counter), fc);
    chk({tag, "_part"},  32'(part),          pt);
    chk({tag, "_fip"},   32'(frame_in_part), fip);
    chk({tag, "_fade"},  32'(fade),          fd);
    chk({tag, "_beat"},  32'(beat_tick),     bt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tick"}, 32'(frame_tick),    32'd0);
    chk({tag, "_fc"},   32'(frame_counter), 32'd0);
    chk({tag, "_part"}, 32'(part),          32'd0);
    chk({tag, "_fip"},  32'(frame_in_part), 32'd0);
    chk({tag, "_fade"}, 32'(fade),          32'd0);
    chk({tag, "_beat"}, 32'(beat_tick),     32'd0);
  endtask

  // Low for two cycles then high; returns at the negedge where the tick is visible.
  task automatic pulse_vsync();
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
  endtask

  // One advancing frame with the expected state stepped forward by the bench.
  task automatic model_frame(input string tag);
    e_fc = (e_fc + 1) % 4096;
    if (e_fip == 31) begin
      e_fip  = 0;
      e_part = (e_part + 1) % 3;
    end else begin
      e_fip = e_fip + 1;
    end
    pulse_vsync();
    check_frame($sformatf("%s_fc%0d", tag, e_fc), e_fc, e_part, e_fip, exp_fade(e_fip),
                ((e_fc % 32) == 0) ? 1 : 0);
  endtask

  initial begin
    // pause, steps, sel_en, sel -> fc, part, fip, fade
    vecs[0]  = '{1'b0, 0, 1'b0, 3'd0,  2, 0, 2, 0};
    vecs[1]  = '{1'b0, 0, 1'b0, 3'd0,  3, 0, 3, 0};
    vecs[2]  = '{1'b0, 0, 1'b0, 3'd0,  4, 0, 4, 1};
    vecs[3]  = '{1'b1, 0, 1'b0, 3'd0,  4, 0, 4, 1};
    vecs[4]  = '{1'b1, 1, 1'b0, 3'd0,  5, 0, 5, 1};
    vecs[5]  = '{1'b1, 2, 1'b0, 3'd0,  6, 0, 6, 1};
    vecs[6]  = '{1'b1, 0, 1'b0, 3'd0,  6, 0, 6, 1};
    vecs[7]  = '{1'b0, 0, 1'b0, 3'd0,  7, 0, 7, 1};
    vecs[8]  = '{1'b0, 0, 1'b0, 3'd0,  8, 0, 8, 2};
    vecs[9]  = '{1'b0, 0, 1'b1, 3'd2,  9, 2, 0, 0};
    vecs[10] = '{1'b0, 0, 1'b1, 3'd2, 10, 2, 1, 0};
    vecs[11] = '{1'b0, 0, 1'b1, 3'd7, 11, 2, 2, 0};
    vecs[12] = '{1'b0, 0, 1'b1, 3'd3, 12, 2, 3, 0};
    vecs[13] = '{1'b0, 0, 1'b0, 3'd0, 13, 2, 4, 1};
    vecs[14] = '{1'b1, 0, 1'b1, 3'd0, 13, 2, 4, 1};
    vecs[15] = '{1'b0, 0, 1'b1, 3'd0, 14, 0, 0, 0};
    vecs[16] = '{1'b0, 1, 1'b0, 3'd0, 15, 0, 1, 0};
    vecs[17] = '{1'b1, 0, 1'b0, 3'd0, 15, 0, 1, 0};

    rst_n = 1'b0; vsync = 1'b1; pause = 1'b0; step = 1'b0;
    part_sel_en = 1'b0; part_sel = 3'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rel_hi_notick%0d", i), 32'(frame_tick), 32'd0);
    end

    vsync = 1'b0;
    repeat (10) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check_frame("first", 1, 0, 1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
    end
    chk("held_high_ticks", ticks, 32'd0);

    prev_part = 0;
    for (int i = 0; i < 18; i++) begin
      vsync       = 1'b0;
      pause       = vecs[i].pause;
      part_sel_en = vecs[i].sel_en;
      part_sel    = vecs[i].sel;
      @(negedge clk);
      for (int k = 0; k < vecs[i].steps; k++) begin
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("v%0d_pre_part", i), 32'(part), prev_part);
      vsync = 1'b1;
      @(negedge clk);
      check_frame($sformatf("v%0d", i), vecs[i].fc, vecs[i].part, vecs[i].fip,
                  vecs[i].fade, 0);
      prev_part = vecs[i].part;
    end
    part_sel_en = 1'b0;
    e_fc = 15; e_part = 0; e_fip = 1;

    // Step edge on the same edge as the rise: recorded, no advance yet.
    pause = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    step  = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_frame("simul_step", 15, 0, 1, 0, 0);
    model_frame("simul_next");

    // Pending step is dropped when pause falls before the rise.
    vsync = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check_frame("pause_fall_clr", e_fc, e_part, e_fip, exp_fade(e_fip), 0);
    pause = 1'b0;

    // Override on the same rise as the natural part wrap.
    while (e_fip != 31) model_frame("to_wrap");
    part_sel_en = 1'b1;
    part_sel    = 3'((e_part + 2) % 3);
    e_fc   = e_fc + 1;
    e_fip  = 0;
    e_part = (e_part + 2) % 3;
    pulse_vsync();
    check_frame("ovr_wrap", e_fc, e_part, e_fip, 0, ((e_fc % 32) == 0) ? 1 : 0);
    part_sel_en = 1'b0;

    while (e_fc != 300) model_frame("run");

    // Reset mid-part with vsync held high.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_vals($sformatf("midrst%0d", i));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_vals($sformatf("postrst%0d", i));
    end
    e_fc = 0; e_part = 0; e_fip = 0;

    // Full counter lap: beats every 32 frames, wrap 4095 -> 0 is a beat.
    for (int i = 0; i < 4096; i++) model_frame("lap");
    chk("wrap_fc", 32'(frame_counter), 32'd0);
    chk("wrap_beat", 32'(beat_tick), 32'd1);
    @(negedge clk);
    chk("beat_single", 32'(beat_tick), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
